// File: rtl/mac_accumulator.sv
// mac_accumulator: frame accumulator for signed, saturated multiplier products.
//   Beats are summed into a signed ACC_W accumulator that saturates
//   symmetrically. A frame closes on in_last or on the LEN-th beat. The
//   frame sum is then saturated to DATA_W and held on out_data until the
//   consumer takes it.
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   clr                   synchronous frame abort (drops any beat this cycle)
//   in_valid/in_ready     input handshake; in_data is the sample, in_last closes the frame
//   out_valid/out_ready   result handshake; out_data is the saturated sum
//   out_ovf               saturation occurred somewhere in the held frame
//   busy                  a frame is open (ACCUM or OUTPUT)
module mac_accumulator #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  // Symmetric clamp values: the most negative code is never produced.
  localparam logic signed [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] D_POS   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] D_NEG   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] acc, acc_new;
  logic signed [ACC_W:0]   sum;
  logic [CNT_W-1:0]        cnt, cnt_new;
  logic                    ovf, ovf_new;
  logic                    acc_clamp;
  logic                    sat_clamp;
  logic [DATA_W-1:0]       sat_data;
  logic                    accept;
  logic                    close;

  // Datapath: next accumulator, count, sticky overflow and saturated result.
  always_comb begin
    sum       = '0;
    acc_new   = '0;
    acc_clamp = 1'b0;
    cnt_new   = '0;
    ovf_new   = 1'b0;
    sat_clamp = 1'b0;
    sat_data  = '0;

    // One guard bit; in IDLE the previous accumulator is ignored so the
    // beat loads rather than adds.
    sum = {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
    if (state == ACCUM) begin
      sum = sum + {acc[ACC_W-1], acc};
    end

    // Overflow when the guard bit disagrees with the ACC_W sign bit.
    acc_clamp = sum[ACC_W] != sum[ACC_W-1];
    if (acc_clamp) begin
      acc_new = sum[ACC_W] ? ACC_NEG : ACC_POS;
    end else begin
      acc_new = sum[ACC_W-1:0];
    end

    cnt_new = (state == ACCUM) ? cnt + 1'b1 : CNT_W'(1);
    ovf_new = ((state == ACCUM) && ovf) || acc_clamp;

    if (acc_new > D_POS) begin
      sat_clamp = 1'b1;
      sat_data  = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (acc_new < D_NEG) begin
      sat_clamp = 1'b1;
      sat_data  = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
    end else begin
      sat_data  = acc_new[DATA_W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = (state != OUTPUT);
    out_valid  = (state == OUTPUT);
    busy       = (state != IDLE);
    accept     = in_valid && (state != OUTPUT) && !clr;
    close      = accept && (in_last || (cnt_new == LEN_C));

    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = close ? OUTPUT : ACCUM;
        ACCUM:   if (close)  state_next = OUTPUT;
        OUTPUT:  if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Accumulator, counter, sticky flag and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (out_valid && out_ready) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_new;
      cnt <= cnt_new;
      ovf <= ovf_new || (close && sat_clamp);
      if (close) begin
        out_data <= sat_data;
        out_ovf  <= ovf_new || sat_clamp;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed test of mac_accumulator with default
// parameters (dut) and with ACC_W=17 (dut17).
module tb_mac_accumulator;

  logic        clk;
  logic        rst_n;

  logic        clr, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [15:0] out_data;

  logic        clr17, in_valid17, in_last17, out_ready17;
  logic [15:0] in_data17;
  logic        in_ready17, out_valid17, out_ovf17, busy17;
  logic [15:0] out_data17;

  int n_assert = 0;
  int n_fail   = 0;

  mac_accumulator #(.DATA_W(16), .ACC_W(24), .LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  mac_accumulator #(.DATA_W(16), .ACC_W(17), .LEN(16)) dut17 (
    .clk(clk), .rst_n(rst_n), .clr(clr17),
    .in_valid(in_valid17), .in_ready(in_ready17), .in_data(in_data17), .in_last(in_last17),
    .out_valid(out_valid17), .out_ready(out_ready17), .out_data(out_data17),
    .out_ovf(out_ovf17), .busy(busy17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send17(input logic [15:0] d, input logic last);
    in_valid17 = 1'b1;
    in_data17  = d;
    in_last17  = last;
    step();
    in_valid17 = 1'b0;
    in_last17  = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
    clr17 = 1'b0; in_valid17 = 1'b0; in_last17 = 1'b0; out_ready17 = 1'b0; in_data17 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    step();

    // Four beats of 0x0100, last on the 4th
    send(16'h0100, 1'b0);
    chk("f4_busy", 32'(busy), 32'd1);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    chk("f4_valid_early", 32'(out_valid), 32'd0);
    send(16'h0100, 1'b1);
    chk("f4_valid",    32'(out_valid), 32'd1);
    chk("f4_data",     32'(out_data),  32'h0400);
    chk("f4_ovf",      32'(out_ovf),   32'd0);
    chk("f4_in_ready", 32'(in_ready),  32'd0);
    drain("f4");

    // 16 beats of 0x7FFF, no last: closes on the LEN-th beat
    for (int i = 0; i < 15; i++) send(16'h7FFF, 1'b0);
    chk("pos16_valid_early", 32'(out_valid), 32'd0);
    send(16'h7FFF, 1'b0);
    chk("pos16_valid", 32'(out_valid), 32'd1);
    chk("pos16_data",  32'(out_data),  32'h7FFF);
    chk("pos16_ovf",   32'(out_ovf),   32'd1);
    drain("pos16");

    for (int i = 0; i < 16; i++) send(16'h8001, 1'b0);
    chk("neg16_valid", 32'(out_valid), 32'd1);
    chk("neg16_data",  32'(out_data),  32'h8001);
    chk("neg16_ovf",   32'(out_ovf),   32'd1);
    drain("neg16");

    // Opposite extremes cancel; sticky flag must not leak from previous frame
    send(16'h8001, 1'b0);
    send(16'h7FFF, 1'b1);
    chk("cancel_valid", 32'(out_valid), 32'd1);
    chk("cancel_data",  32'(out_data),  32'h0000);
    chk("cancel_ovf",   32'(out_ovf),   32'd0);
    drain("cancel");

    // Backpressure on the result with input offered
    send(16'h0005, 1'b1);
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 16'h0077; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_data",     32'(out_data),  32'h0005);
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy",  32'(busy),      32'd0);
    step();
    chk("bp_no_beat_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-frame
    send(16'h1234, 1'b0);
    send(16'h1111, 1'b0);
    chk("ar_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy",      32'(busy),      32'd0);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data",  32'(out_data),  32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    step();
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b1);
    chk("ar_next_valid", 32'(out_valid), 32'd1);
    chk("ar_next_data",  32'(out_data),  32'h0030);
    chk("ar_next_ovf",   32'(out_ovf),   32'd0);
    drain("ar");

    // ACC_W=17: accumulator clamps at 0x0FFFF
    send17(16'h7FFF, 1'b0);
    send17(16'h7FFF, 1'b0);
    send17(16'h7FFF, 1'b1);
    chk("a17_valid", 32'(out_valid17), 32'd1);
    chk("a17_acc",   32'(dut17.acc),   32'h0000FFFF);
    chk("a17_data",  32'(out_data17),  32'h7FFF);
    chk("a17_ovf",   32'(out_ovf17),   32'd1);

    // clr while result pending, with a beat offered
    clr17 = 1'b1; in_valid17 = 1'b1; in_data17 = 16'h0100;
    step();
    chk("clr_out_valid", 32'(out_valid17), 32'd0);
    chk("clr_out_data",  32'(out_data17),  32'd0);
    chk("clr_out_ovf",   32'(out_ovf17),   32'd0);
    chk("clr_busy",      32'(busy17),      32'd0);
    chk("clr_in_ready",  32'(in_ready17),  32'd1);
    // clr in IDLE with a beat: beat dropped
    step();
    clr17 = 1'b0; in_valid17 = 1'b0;
    chk("clr_idle_busy", 32'(busy17), 32'd0);
    send17(16'h0003, 1'b1);
    chk("clr_next_data", 32'(out_data17), 32'h0003);
    chk("clr_next_ovf",  32'(out_ovf17),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The parameter SHALL be DATA_W, default 16, meaning width of signed two's-complement product samples and of the result.
REQ-002 The parameter SHALL be ACC_W, default 24, meaning signed internal accumulator width; legal range DATA_W+1..32.
REQ-003 The parameter SHALL be LEN, default 16, meaning maximum beats per frame; legal range 1..256.
REQ-004 The port SHALL be clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The port SHALL be rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-006 The port SHALL be clr, input, 1, meaning synchronous frame abort.
REQ-007 The port SHALL be in_valid, input, 1, meaning a product sample is present.
REQ-008 The port SHALL be in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-009 The port SHALL be in_data, input, DATA_W, meaning a signed saturated product from the multiplier stage.
REQ-010 The port SHALL be in_last, input, 1, meaning the current beat closes the frame.
REQ-011 The port SHALL be out_valid, output, 1, meaning a frame result is held.
REQ-012 The port SHALL be out_ready, input, 1, meaning the consumer takes the result.
REQ-013 The port SHALL be out_data, output, DATA_W, meaning the saturated frame sum.
REQ-014 The port SHALL be out_ovf, output, 1, meaning saturation occurred somewhere in this frame.
REQ-015 The port SHALL be busy, output, 1, meaning a frame is open (state ACCUM or OUTPUT).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM, OUTPUT.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in OUTPUT; a beat transfers only when in_valid and in_ready are both 1.
REQ-018 A beat accepted in IDLE SHALL load acc = sign-extended in_data, set cnt = 1, and move to ACCUM.
REQ-019 A beat accepted in ACCUM SHALL set acc = acc + sign-extended in_data and increment cnt.
REQ-020 If the sum exceeds the ACC_W signed range, acc SHALL clamp to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)-1) and a sticky ovf flag SHALL set.
REQ-021 A frame SHALL close on the accepted beat carrying in_last=1 or on the LEN-th accepted beat, whichever comes first; in_last on a beat accepted in IDLE closes a 1-beat frame.
REQ-022 On close, out_data SHALL register sat(acc_new) in the same edge, and the FSM SHALL enter OUTPUT, giving out_valid=1 in the cycle after the closing beat (latency 1).
REQ-023 sat() SHALL map values above 2^(DATA_W-1)-1 to 16'h7FFF and values below -(2^(DATA_W-1)-1) to 16'h8001 (symmetric, for DATA_W=16); either clamp SHALL set ovf.
REQ-024 out_ovf SHALL equal ovf for the closed frame and be valid whenever out_valid=1.
REQ-025 In OUTPUT, out_data and out_ovf SHALL hold stable while out_ready=0.
REQ-026 When out_valid and out_ready are both 1, the FSM SHALL return to IDLE with acc, cnt, and ovf cleared; out_valid=0 next cycle; no input beat is accepted in that cycle.
REQ-027 clr=1 SHALL force IDLE, out_valid=0, and acc, cnt, ovf, out_data, out_ovf all 0 at the next edge, discarding any beat presented in that cycle (in_ready still reads 1 but the beat is dropped).
REQ-028 busy SHALL be 1 in ACCUM and OUTPUT and 0 in IDLE.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force IDLE with acc=0, cnt=0, ovf=0, out_valid=0, out_data=0, out_ovf=0, busy=0; in_ready SHALL follow state (1 in IDLE).
REQ-030 Reset deassertion SHALL take effect on the next clk edge, and the first accepted beat SHALL start a fresh frame.

Verification
REQ-031 Four beats of 0x0100 with in_last on the 4th -> out_valid rises 1 cycle later, out_data=0x0400, out_ovf=0.
REQ-032 Default LEN, 16 beats of 0x7FFF, no in_last -> frame closes on the 16th beat; out_data=0x7FFF, out_ovf=1; likewise 16 beats of 0x8001 -> out_data=0x8001, out_ovf=1.
REQ-033 Beats 0x8001 then 0x7FFF with last -> out_data=0x0000, out_ovf=0.
REQ-034 Result pending, out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, no beats consumed; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low asynchronously mid-frame after 2 beats -> all outputs 0 immediately; next frame of 0x0010, 0x0020 (last) -> 0x0030.
REQ-036 ACC_W=17, beats 0x7FFF, 0x7FFF, 0x7FFF (last) -> acc clamps at 0x0FFFF; out_data=0x7FFF, out_ovf=1; clr asserted with a beat afterwards -> beat dropped, busy=0.
